// File: rtl/qu_common_pkg.sv
// Shared types for the qu_* pipeline blocks: ROB sizing, cell layout and cell states.
package qu_common;

  localparam int ROB_DEPTH      = 8;
  localparam int ROB_ADDR_WIDTH = $clog2(ROB_DEPTH);

  typedef logic [ROB_ADDR_WIDTH-1:0] rob_addr_t;
  typedef logic [5:0]                phy_rf_addr_t;
  typedef logic [31:0]               dest_t;
  typedef logic [1:0]                rob_state_t;

  // state     | meaning
  // EMPTY     | slot free
  // PENDING   | allocated, not yet issued
  // EXECUTE   | issued to a functional unit
  // RETIRED   | result written back, waiting to commit
  localparam rob_state_t ROB_STATE_EMPTY   = 2'd0;
  localparam rob_state_t ROB_STATE_PENDING = 2'd1;
  localparam rob_state_t ROB_STATE_EXECUTE = 2'd2;
  localparam rob_state_t ROB_STATE_RETIRED = 2'd3;

  // dest is a physical register number, or a memory address when store is set
  typedef struct packed {
    rob_state_t   state;
    logic         store;
    dest_t        dest;
    phy_rf_addr_t phyreg_old;
    logic [31:0]  value;
    logic         mispredicted_branch;
  } rob_cell_t;

endpackage

// File: rtl/qu_rob.sv
// In-order reorder buffer: tail allocation, out-of-order writeback, in-order commit with flush.
// Optional reservation-station operand read ports under QU_ROB_OPERAND_FWD_EN.
module qu_rob
  import qu_common::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alloc_valid_i,
  output logic         alloc_ready_o,
  input  rob_cell_t    alloc_cell_i,
  output logic [AW-1:0] alloc_addr_o,
  input  logic         issue_valid_i,
  input  logic [AW-1:0] issue_addr_i,
  input  logic         wb_valid_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [31:0]  wb_value_i,
  input  logic [31:0]  wb_dest_i,
  input  logic         wb_mispredict_i,
  output logic         commit_valid_o,
  input  logic         commit_ready_i,
  output rob_cell_t    commit_cell_o,
  output logic         free_valid_o,
  output phy_rf_addr_t free_phyreg_o,
  output logic         flush_o,
`ifdef QU_ROB_OPERAND_FWD_EN
  input  logic [AW-1:0] fwd_addr_j_i,
  input  logic [AW-1:0] fwd_addr_k_i,
  output logic         fwd_valid_j_o,
  output logic [31:0]  fwd_value_j_o,
  output logic         fwd_valid_k_o,
  output logic [31:0]  fwd_value_k_o,
`endif
  output logic [AW:0]  count_o
);

  rob_cell_t    cells [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]  count;
  logic         flush_q;
  logic         free_valid_q;
  phy_rf_addr_t free_phyreg_q;

  logic      alloc_fire, commit_fire, issue_take, wb_take;
  rob_cell_t alloc_cell;

  assign alloc_ready_o  = (count != (AW+1)'(DEPTH)) && !flush_q;
  assign alloc_addr_o   = tail;
  assign commit_cell_o  = cells[head];
  assign commit_valid_o = (cells[head].state == ROB_STATE_RETIRED);
  assign free_valid_o   = free_valid_q;
  assign free_phyreg_o  = free_phyreg_q;
  assign flush_o        = flush_q;
  assign count_o        = count;

  assign alloc_fire  = alloc_valid_i && alloc_ready_o;
  assign commit_fire = commit_valid_o && commit_ready_i;
  assign issue_take  = issue_valid_i && !flush_q &&
                       (cells[issue_addr_i].state == ROB_STATE_PENDING);
  assign wb_take     = wb_valid_i && !flush_q &&
                       ((cells[wb_addr_i].state == ROB_STATE_PENDING) ||
                        (cells[wb_addr_i].state == ROB_STATE_EXECUTE));

  always_comb begin
    alloc_cell                     = alloc_cell_i;
    alloc_cell.state               = ROB_STATE_PENDING;
    alloc_cell.value               = '0;
    alloc_cell.mispredicted_branch = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      flush_q       <= 1'b0;
      free_valid_q  <= 1'b0;
      free_phyreg_q <= '0;
    end else begin
      flush_q       <= 1'b0;
      free_valid_q  <= commit_fire && !cells[head].store;
      free_phyreg_q <= commit_fire ? cells[head].phyreg_old : '0;
      if (commit_fire && cells[head].mispredicted_branch) begin
        // everything younger than the branch is wrong-path; same-cycle alloc is dropped too
        for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        flush_q <= 1'b1;
      end else begin
        if (issue_take) cells[issue_addr_i].state <= ROB_STATE_EXECUTE;
        // placed after issue so a same-address writeback wins
        if (wb_take) begin
          cells[wb_addr_i].state               <= ROB_STATE_RETIRED;
          cells[wb_addr_i].value               <= wb_value_i;
          cells[wb_addr_i].mispredicted_branch <= wb_mispredict_i;
          if (cells[wb_addr_i].store) cells[wb_addr_i].dest <= wb_dest_i;
        end
        if (commit_fire) begin
          cells[head].state <= ROB_STATE_EMPTY;
          head              <= head + 1'b1;
        end
        if (alloc_fire) begin
          cells[tail] <= alloc_cell;
          tail        <= tail + 1'b1;
        end
        case ({alloc_fire, commit_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef QU_ROB_OPERAND_FWD_EN
  always_comb begin
    fwd_valid_j_o = (cells[fwd_addr_j_i].state == ROB_STATE_RETIRED);
    fwd_value_j_o = cells[fwd_addr_j_i].value;
    fwd_valid_k_o = (cells[fwd_addr_k_i].state == ROB_STATE_RETIRED);
    fwd_value_k_o = cells[fwd_addr_k_i].value;
    if (wb_take && (wb_addr_i == fwd_addr_j_i)) begin
      fwd_valid_j_o = 1'b1;
      fwd_value_j_o = wb_value_i;
    end
    if (wb_take && (wb_addr_i == fwd_addr_k_i)) begin
      fwd_valid_k_o = 1'b1;
      fwd_value_k_o = wb_value_i;
    end
  end
`endif

endmodule

// File: tb/tb_qu_rob.sv
// Directed self-checking bench for qu_rob; covers fwd ports when QU_ROB_OPERAND_FWD_EN is defined.
module tb_qu_rob;
  import qu_common::*;

  localparam int AW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_valid_i, alloc_ready_o;
  rob_cell_t    alloc_cell_i;
  logic [AW-1:0] alloc_addr_o;
  logic         issue_valid_i;
  logic [AW-1:0] issue_addr_i;
  logic         wb_valid_i;
  logic [AW-1:0] wb_addr_i;
  logic [31:0]  wb_value_i, wb_dest_i;
  logic         wb_mispredict_i;
  logic         commit_valid_o, commit_ready_i;
  rob_cell_t    commit_cell_o;
  logic         free_valid_o;
  phy_rf_addr_t free_phyreg_o;
  logic         flush_o;
  logic [AW:0]  count_o;
`ifdef QU_ROB_OPERAND_FWD_EN
  logic [AW-1:0] fwd_addr_j_i, fwd_addr_k_i;
  logic         fwd_valid_j_o, fwd_valid_k_o;
  logic [31:0]  fwd_value_j_o, fwd_value_k_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qu_rob dut (
    .clk(clk), .rst(rst),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_cell_i(alloc_cell_i), .alloc_addr_o(alloc_addr_o),
    .issue_valid_i(issue_valid_i), .issue_addr_i(issue_addr_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_value_i(wb_value_i),
    .wb_dest_i(wb_dest_i), .wb_mispredict_i(wb_mispredict_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_cell_o(commit_cell_o),
    .free_valid_o(free_valid_o), .free_phyreg_o(free_phyreg_o),
    .flush_o(flush_o),
`ifdef QU_ROB_OPERAND_FWD_EN
    .fwd_addr_j_i(fwd_addr_j_i), .fwd_addr_k_i(fwd_addr_k_i),
    .fwd_valid_j_o(fwd_valid_j_o), .fwd_value_j_o(fwd_value_j_o),
    .fwd_valid_k_o(fwd_valid_k_o), .fwd_value_k_o(fwd_value_k_o),
`endif
    .count_o(count_o)
  );

  // inputs change on negedge; registered results are looked at on the following negedge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid_i = 0; alloc_cell_i = '0;
    issue_valid_i = 0; issue_addr_i = '0;
    wb_valid_i = 0; wb_addr_i = '0; wb_value_i = '0; wb_dest_i = '0; wb_mispredict_i = 0;
    commit_ready_i = 0;
`ifdef QU_ROB_OPERAND_FWD_EN
    fwd_addr_j_i = '0; fwd_addr_k_i = '0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic alloc_one(input logic [31:0] dest, input logic [5:0] old, input logic st);
    alloc_valid_i = 1;
    alloc_cell_i = '0;
    alloc_cell_i.dest = dest; alloc_cell_i.phyreg_old = old; alloc_cell_i.store = st;
    alloc_cell_i.value = 32'hDEAD_BEEF; alloc_cell_i.state = ROB_STATE_RETIRED;
    alloc_cell_i.mispredicted_branch = 1;
    tick();
    alloc_valid_i = 0;
  endtask

  task automatic wb_one(input logic [AW-1:0] a, input logic [31:0] v, input logic [31:0] d, input logic mp);
    wb_valid_i = 1; wb_addr_i = a; wb_value_i = v; wb_dest_i = d; wb_mispredict_i = mp;
    tick();
    wb_valid_i = 0; wb_mispredict_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0d want 1", alloc_ready_o); end
    n_checks++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid got %0d want 0", commit_valid_o); end
    n_checks++; if (free_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_free got %0d want 0", free_valid_o); end
    n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %0d want 0", flush_o); end
    n_checks++; if (alloc_addr_o !== 3'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", alloc_addr_o); end
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_checks++; if (commit_cell_o !== '0) begin n_fail++; $display("FAIL reset_cell got %0h want 0", commit_cell_o); end
    // reset in the same cycle as a commit handshake suppresses the free pulse
    alloc_one(32'd1, 6'd9, 1'b0);
    wb_one(3'd0, 32'h1, 32'h0, 1'b0);
    commit_ready_i = 1; rst = 1;
    tick();
    rst = 0; commit_ready_i = 0;
    n_checks++; if (free_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_over_free got %0d want 0", free_valid_o); end
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_mid_count got %0d want 0", count_o); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (alloc_addr_o !== 3'(i)) begin n_fail++; $display("FAIL fill_addr%0d got %0d want %0d", i, alloc_addr_o, i); end
      n_checks++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d got %0d want 1", i, alloc_ready_o); end
      alloc_one(32'(i + 1), 6'(i), 1'b0);
    end
    n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d want 8", count_o); end
    n_checks++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got %0d want 0", alloc_ready_o); end
    n_checks++; if (commit_cell_o.state !== ROB_STATE_PENDING) begin n_fail++; $display("FAIL fill_state got %0d want 1", commit_cell_o.state); end
    n_checks++; if (commit_cell_o.value !== 32'h0) begin n_fail++; $display("FAIL fill_value got %0h want 0", commit_cell_o.value); end
    n_checks++; if (commit_cell_o.mispredicted_branch !== 1'b0) begin n_fail++; $display("FAIL fill_mp got %0d want 0", commit_cell_o.mispredicted_branch); end
    alloc_one(32'd9, 6'd9, 1'b0);
    n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL ninth_count got %0d want 8", count_o); end
    n_checks++; if (commit_cell_o.dest !== 32'd1) begin n_fail++; $display("FAIL ninth_head_dest got %0d want 1", commit_cell_o.dest); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) alloc_one(32'(i + 1), 6'(10 + i), 1'b0);
    wb_one(3'd2, 32'h33, 32'h0, 1'b0);
    n_checks++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL ooo_valid_early got %0d want 0", commit_valid_o); end
    wb_one(3'd0, 32'h10, 32'h0, 1'b0);
    n_checks++; if (commit_valid_o !== 1'b1) begin n_fail++; $display("FAIL ooo_valid_head got %0d want 1", commit_valid_o); end
    n_checks++; if (commit_cell_o.value !== 32'h10) begin n_fail++; $display("FAIL ooo_value0 got %0h want 10", commit_cell_o.value); end
    wb_one(3'd1, 32'h11, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      commit_ready_i = 1;
      n_checks++; if (commit_valid_o !== 1'b1) begin n_fail++; $display("FAIL ooo_cv%0d got %0d want 1", i, commit_valid_o); end
      n_checks++; if (commit_cell_o.dest !== 32'(i + 1)) begin n_fail++; $display("FAIL ooo_dest%0d got %0d want %0d", i, commit_cell_o.dest, i + 1); end
      n_checks++; if (free_valid_o !== (i != 0)) begin n_fail++; $display("FAIL ooo_free_pre%0d got %0d want %0d", i, free_valid_o, i != 0); end
      tick();
      commit_ready_i = 0;
      n_checks++; if (free_valid_o !== 1'b1) begin n_fail++; $display("FAIL ooo_free%0d got %0d want 1", i, free_valid_o); end
      n_checks++; if (free_phyreg_o !== 6'(10 + i)) begin n_fail++; $display("FAIL ooo_phy%0d got %0d want %0d", i, free_phyreg_o, 10 + i); end
    end
    tick();
    n_checks++; if (free_valid_o !== 1'b0) begin n_fail++; $display("FAIL ooo_free_end got %0d want 0", free_valid_o); end
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL ooo_count got %0d want 0", count_o); end
  endtask

  task automatic test_issue_priority();
    do_reset();
    alloc_one(32'd1, 6'd1, 1'b0);
    alloc_one(32'd2, 6'd2, 1'b0);
    issue_valid_i = 1; issue_addr_i = 3'd0;
    tick();
    n_checks++; if (commit_cell_o.state !== ROB_STATE_EXECUTE) begin n_fail++; $display("FAIL issue_state got %0d want 2", commit_cell_o.state); end
    issue_addr_i = 3'd1; wb_valid_i = 1; wb_addr_i = 3'd1; wb_value_i = 32'h22;
    tick();
    issue_valid_i = 0; wb_valid_i = 0;
    wb_one(3'd0, 32'h21, 32'h0, 1'b0);
    commit_ready_i = 1;
    tick();
    commit_ready_i = 0;
    issue_valid_i = 1; issue_addr_i = 3'd1;
    tick();
    issue_valid_i = 0;
    n_checks++; if (commit_cell_o.state !== ROB_STATE_RETIRED) begin n_fail++; $display("FAIL wb_over_issue got %0d want 3", commit_cell_o.state); end
    n_checks++; if (commit_cell_o.value !== 32'h22) begin n_fail++; $display("FAIL wb_over_issue_val got %0h want 22", commit_cell_o.value); end
    wb_one(3'd1, 32'h99, 32'h0, 1'b0);
    n_checks++; if (commit_cell_o.value !== 32'h22) begin n_fail++; $display("FAIL wb_retired_ignored got %0h want 22", commit_cell_o.value); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) alloc_one(32'(i + 1), 6'(20 + i), 1'b0);
    wb_one(3'd0, 32'h7, 32'h0, 1'b0);
    commit_ready_i = 1; alloc_valid_i = 1; alloc_cell_i = '0; alloc_cell_i.dest = 32'd9; alloc_cell_i.phyreg_old = 6'd29;
    n_checks++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %0d want 0", alloc_ready_o); end
    n_checks++; if (commit_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_cv got %0d want 1", commit_valid_o); end
    tick();
    commit_ready_i = 0;
    n_checks++; if (count_o !== 4'd7) begin n_fail++; $display("FAIL b2b_count7 got %0d want 7", count_o); end
    n_checks++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %0d want 1", alloc_ready_o); end
    n_checks++; if (alloc_addr_o !== 3'd0) begin n_fail++; $display("FAIL b2b_addr got %0d want 0", alloc_addr_o); end
    n_checks++; if (free_phyreg_o !== 6'd20 || free_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_free got %0d/%0d want 1/20", free_valid_o, free_phyreg_o); end
    tick();
    alloc_valid_i = 0;
    n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL b2b_count8 got %0d want 8", count_o); end
    n_checks++; if (commit_cell_o.dest !== 32'd2) begin n_fail++; $display("FAIL b2b_head got %0d want 2", commit_cell_o.dest); end
  endtask

  task automatic test_store();
    do_reset();
    alloc_one(32'd0, 6'd5, 1'b1);
    alloc_one(32'd4, 6'd6, 1'b0);
    wb_one(3'd0, 32'hAB, 32'h100, 1'b0);
    wb_one(3'd1, 32'hCD, 32'h999, 1'b0);
    n_checks++; if (commit_cell_o.dest !== 32'h100) begin n_fail++; $display("FAIL store_dest got %0h want 100", commit_cell_o.dest); end
    n_checks++; if (commit_cell_o.store !== 1'b1) begin n_fail++; $display("FAIL store_flag got %0d want 1", commit_cell_o.store); end
    n_checks++; if (commit_cell_o.value !== 32'hAB) begin n_fail++; $display("FAIL store_value got %0h want ab", commit_cell_o.value); end
    commit_ready_i = 1;
    tick();
    commit_ready_i = 0;
    n_checks++; if (free_valid_o !== 1'b0) begin n_fail++; $display("FAIL store_free got %0d want 0", free_valid_o); end
    n_checks++; if (commit_cell_o.dest !== 32'd4) begin n_fail++; $display("FAIL nonstore_dest got %0h want 4", commit_cell_o.dest); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one(32'(i + 1), 6'(30 + i), 1'b0);
    wb_one(3'd1, 32'h1, 32'h0, 1'b1);
    wb_one(3'd0, 32'h0, 32'h0, 1'b0);
    wb_one(3'd2, 32'h2, 32'h0, 1'b0);
    commit_ready_i = 1;
    tick();
    n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL flush_early got %0d want 0", flush_o); end
    n_checks++; if (commit_cell_o.mispredicted_branch !== 1'b1) begin n_fail++; $display("FAIL flush_mp_flag got %0d want 1", commit_cell_o.mispredicted_branch); end
    alloc_valid_i = 1; alloc_cell_i = '0; alloc_cell_i.dest = 32'd77;
    tick();
    commit_ready_i = 0;
    wb_valid_i = 1; wb_addr_i = 3'd0; wb_value_i = 32'h5;
    n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL flush_pulse got %0d want 1", flush_o); end
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count_o); end
    n_checks++; if (alloc_addr_o !== 3'd0) begin n_fail++; $display("FAIL flush_addr got %0d want 0", alloc_addr_o); end
    n_checks++; if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0d want 0", alloc_ready_o); end
    n_checks++; if (commit_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_cv got %0d want 0", commit_valid_o); end
    tick();
    idle();
    n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL flush_one_cycle got %0d want 0", flush_o); end
    n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL flush_alloc_dropped got %0d want 0", count_o); end
    n_checks++; if (commit_cell_o.state !== ROB_STATE_EMPTY) begin n_fail++; $display("FAIL flush_wb_ignored got %0d want 0", commit_cell_o.state); end
    n_checks++; if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready_back got %0d want 1", alloc_ready_o); end
  endtask

`ifdef QU_ROB_OPERAND_FWD_EN
  task automatic test_fwd();
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(32'(i + 1), 6'(i), 1'b0);
    wb_valid_i = 1; wb_addr_i = 3'd3; wb_value_i = 32'h55;
    fwd_addr_j_i = 3'd3; fwd_addr_k_i = 3'd1;
    #1;
    n_checks++; if (fwd_valid_j_o !== 1'b1 || fwd_value_j_o !== 32'h55) begin n_fail++; $display("FAIL fwd_bypass got %0d/%0h want 1/55", fwd_valid_j_o, fwd_value_j_o); end
    n_checks++; if (fwd_valid_k_o !== 1'b0) begin n_fail++; $display("FAIL fwd_pending got %0d want 0", fwd_valid_k_o); end
    tick();
    wb_valid_i = 0; fwd_addr_k_i = 3'd5;
    #1;
    n_checks++; if (fwd_valid_j_o !== 1'b1 || fwd_value_j_o !== 32'h55) begin n_fail++; $display("FAIL fwd_retired got %0d/%0h want 1/55", fwd_valid_j_o, fwd_value_j_o); end
    n_checks++; if (fwd_valid_k_o !== 1'b0) begin n_fail++; $display("FAIL fwd_empty got %0d want 0", fwd_valid_k_o); end
  endtask
`endif

  initial begin
    idle();
    rst = 1;
    tick();
    test_reset();
    test_fill();
    test_out_of_order();
    test_issue_priority();
    test_back_to_back();
    test_store();
    test_flush();
`ifdef QU_ROB_OPERAND_FWD_EN
    test_fwd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
